// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg
//   Shared definitions for the serial pattern detector controller:
//   FSM state encoding, default parameter values and a saturating
//   increment helper used by the match counter.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  // Width needed to hold the values 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// seq_pattern_match
//   Bit-serial pattern matcher. Keeps the last PAT_W bits received and a
//   fill count of bits seen since the last clear (saturating at PAT_W).
//   A match is flagged combinationally in the cycle the completing bit is
//   presented; the caller registers it.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   bit_valid  data_bit is a new stream bit this cycle
//   data_bit   serial bit, earliest bit ends up in history[PAT_W-1]
//   clear      wipe history and fill (start of a run)
//   pattern    pattern to compare against
//   overlap    1 = keep fill after a match, 0 = restart fill after a match
//   match      a match completes on this cycle's bit
module seq_pattern_match
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             data_bit,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int FILL_W = count_width(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  history_reg, history_next, shifted;
  logic [FILL_W-1:0] fill_reg, fill_next, fill_inc;
  logic              hit;

  // History shifted by one with the new bit entering at position 0;
  // written per bit so PAT_W = 1 needs no special slice.
  genvar gi;
  generate
    for (gi = 0; gi < PAT_W; gi++) begin : g_hist
      if (gi == 0) begin : g_lsb
        assign shifted[gi] = data_bit;
      end else begin : g_upper
        assign shifted[gi] = history_reg[gi-1];
      end
    end
  endgenerate

  assign fill_inc = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
  assign hit      = bit_valid && !clear && (fill_inc == FILL_FULL) && (shifted == pattern);
  assign match    = hit;

  always_comb begin
    history_next = history_reg;
    fill_next    = fill_reg;
    if (clear) begin
      history_next = '0;
      fill_next    = '0;
    end else if (bit_valid) begin
      history_next = shifted;
      // Non-overlapping mode needs a full fresh window before the next match.
      fill_next    = (hit && !overlap) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_reg <= '0;
      fill_reg    <= '0;
    end else begin
      history_reg <= history_next;
      fill_reg    <= fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Controller/sequencer for a serial pattern detector. Accepts words on a
//   valid/ready handshake, serialises them MSB first one bit per clock,
//   counts pattern matches and ends the run at a programmed threshold
//   (checked only at word boundaries).
// Build option
//   SEQ_CTRL_IRQ_EN  when defined, irq is a sticky flag set by the done
//                    pulse or counter saturation and cleared by irq_clr
//                    (set wins). When undefined, irq is tied low.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, stop     run control pulses (stop has priority)
//   cfg_pattern     pattern, bit PAT_W-1 is the earliest bit
//   cfg_overlap     overlapping (1) / non-overlapping (0) detection
//   cfg_threshold   match count ending the run, 0 = run until stop
//   in_valid, in_data, in_ready   word input handshake
//   busy            not IDLE
//   match_pulse     registered pulse, cycle after the completing bit
//   match_count     saturating match count of current/last run
//   done            one-cycle pulse when the run completes
//   irq, irq_clr    sticky interrupt and its clear
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_threshold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              done,
  output logic              irq,
  input  logic              irq_clr
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  shift_reg;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               match_pulse_reg;
  logic [PAT_W-1:0]   pattern_reg;
  logic               overlap_reg;
  logic [CNT_W-1:0]   threshold_reg;

  logic start_ok, accept, bit_valid, last_bit, match, thr_hit;

  // stop masks every other event in the cycle it is asserted.
  assign start_ok  = (state_reg == IDLE)  && start    && !stop;
  assign accept    = (state_reg == ARMED) && in_valid && !stop;
  assign bit_valid = (state_reg == SHIFT) && !stop;
  assign last_bit  = (bit_cnt_reg == LAST_BIT);

  seq_pattern_match #(
    .PAT_W(PAT_W)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .bit_valid(bit_valid),
    .data_bit (shift_reg[DATA_W-1]),
    .clear    (start_ok),
    .pattern  (pattern_reg),
    .overlap  (overlap_reg),
    .match    (match)
  );

  always_comb begin
    count_next = count_reg;
    if (match) begin
      count_next = (count_reg == CNT_MAX) ? count_reg : count_reg + CNT_W'(1);
    end
  end

  // Uses count_next so a match on the word's final bit counts for this word.
  assign thr_hit = (threshold_reg != '0) && (count_next >= threshold_reg);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start)    state_next = ARMED;
        ARMED:   if (in_valid) state_next = SHIFT;
        SHIFT:   if (last_bit) state_next = thr_hit ? DONE : ARMED;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_reg == ARMED);
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE);
  end

  // Word shifter, bit counter, match counter and latched configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      count_reg       <= '0;
      match_pulse_reg <= 1'b0;
      pattern_reg     <= '0;
      overlap_reg     <= 1'b0;
      threshold_reg   <= '0;
    end else begin
      match_pulse_reg <= match;
      if (start_ok) begin
        pattern_reg   <= cfg_pattern;
        overlap_reg   <= cfg_overlap;
        threshold_reg <= cfg_threshold;
        count_reg     <= '0;
      end
      if (accept) begin
        shift_reg   <= in_data;
        bit_cnt_reg <= '0;
      end
      if (bit_valid) begin
        shift_reg   <= shift_reg << 1;
        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
        count_reg   <= count_next;
      end
    end
  end

  assign match_pulse = match_pulse_reg;
  assign match_count = count_reg;

`ifdef SEQ_CTRL_IRQ_EN
  logic irq_reg;
  logic irq_set;

  assign irq_set = (state_reg == DONE) || (match && (count_next == CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst)          irq_reg <= 1'b0;
    else if (irq_set) irq_reg <= 1'b1;
    else if (irq_clr) irq_reg <= 1'b0;
  end

  assign irq = irq_reg;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl
//   Directed test of seq_detect_ctrl: overlap/non-overlap matching,
//   cross-word history, threshold completion, stop and reset behaviour,
//   and the optional irq (SEQ_CTRL_IRQ_EN).
module tb_seq_detect_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 8;

`ifdef SEQ_CTRL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [PAT_W-1:0]  cfg_pattern = '0;
  logic              cfg_overlap = 1'b0;
  logic [CNT_W-1:0]  cfg_threshold = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              busy;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic              done;
  logic              irq;
  logic              irq_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  seq_detect_ctrl #(
    .DATA_W(DATA_W),
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_pattern  (cfg_pattern),
    .cfg_overlap  (cfg_overlap),
    .cfg_threshold(cfg_threshold),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .match_pulse  (match_pulse),
    .match_count  (match_count),
    .done         (done),
    .irq          (irq),
    .irq_clr      (irq_clr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, actual, expected);
    end else begin
      $display("ok   %s: got=%0h", tag, actual);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [PAT_W-1:0] pat, input logic ov, input logic [CNT_W-1:0] thr);
    cfg_pattern   = pat;
    cfg_overlap   = ov;
    cfg_threshold = thr;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("armed_ready", 32'(in_ready), 32'd1);
  endtask

  // Hands one word over and records match_pulse/done after each of its bits.
  // poke raises start during bit 5, which must be ignored outside IDLE.
  task automatic send_word(input logic [DATA_W-1:0] w, input logic poke,
                           output logic [DATA_W-1:0] mask, output logic [DATA_W-1:0] dones);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      start = poke && (k == 4);
      tick();
      mask[k]  = match_pulse;
      dones[k] = done;
    end
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DATA_W-1:0] mask, dones;
    int done_seen;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_busy",  32'(busy),        32'd0);
    check_val("rst_ready", 32'(in_ready),    32'd0);
    check_val("rst_pulse", 32'(match_pulse), 32'd0);
    check_val("rst_done",  32'(done),        32'd0);
    check_val("rst_irq",   32'(irq),         32'd0);
    check_val("rst_count", 32'(match_count), 32'd0);

    // 1: overlap, 1010 on 8'hAA -> matches after bits 4, 6, 8
    start_run(4'b1010, 1'b1, 8'd0);
    send_word(8'hAA, 1'b0, mask, dones);
    check_val("t1_mask",   32'(mask),        32'hA8);
    check_val("t1_count",  32'(match_count), 32'd3);
    check_val("t1_rearm",  32'(in_ready),    32'd1);
    stop_run();
    check_val("t1_idle",   32'(busy),        32'd0);

    // 2: non-overlap, same stimulus -> matches after bits 4 and 8;
    // a start pulse mid-word must not restart the run
    start_run(4'b1010, 1'b0, 8'd0);
    send_word(8'hAA, 1'b1, mask, dones);
    check_val("t2_mask",   32'(mask),        32'h88);
    check_val("t2_count",  32'(match_count), 32'd2);
    stop_run();

    // 3: history carries across words -> one match on bit 1 of second word
    start_run(4'b1010, 1'b1, 8'd0);
    send_word(8'h05, 1'b0, mask, dones);
    check_val("t3_mask_w0", 32'(mask),        32'h00);
    send_word(8'h00, 1'b0, mask, dones);
    check_val("t3_mask_w1", 32'(mask),        32'h01);
    check_val("t3_count",   32'(match_count), 32'd1);
    stop_run();

    // 4: threshold 2 reached at bit 6, run ends only after bit 8
    start_run(4'b1010, 1'b1, 8'd2);
    send_word(8'hAA, 1'b0, mask, dones);
    check_val("t4_mask",   32'(mask),        32'hA8);
    check_val("t4_done",   32'(dones),       32'h80);
    check_val("t4_count",  32'(match_count), 32'd3);
    check_val("t4_busy",   32'(busy),        32'd1);
    tick();
    check_val("t4_done_off", 32'(done),        32'd0);
    check_val("t4_idle",     32'(busy),        32'd0);
    check_val("t4_hold",     32'(match_count), 32'd3);
    check_val("t4_irq",      32'(irq),         32'(IRQ_EN));
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check_val("t4_irq_clr",  32'(irq),         32'd0);

    // 5: stop during bit 3 -> IDLE next cycle, no done, count retained
    start_run(4'b1010, 1'b1, 8'd1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("t5_busy",   32'(busy),        32'd0);
    check_val("t5_ready",  32'(in_ready),    32'd0);
    check_val("t5_count",  32'(match_count), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) done_seen++;
      tick();
    end
    check_val("t5_no_done", 32'(done_seen),  32'd0);
    // start together with stop in IDLE stays IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_val("t5_start_stop", 32'(busy),    32'd0);

    // 6: reset during SHIFT right after a match clears everything
    start_run(4'b1010, 1'b1, 8'd0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_val("t6_pre_pulse", 32'(match_pulse), 32'd1);
    check_val("t6_pre_count", 32'(match_count), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_busy",   32'(busy),        32'd0);
    check_val("t6_ready",  32'(in_ready),    32'd0);
    check_val("t6_pulse",  32'(match_pulse), 32'd0);
    check_val("t6_done",   32'(done),        32'd0);
    check_val("t6_irq",    32'(irq),         32'd0);
    check_val("t6_count",  32'(match_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
